instr_sequencer: RTL and testbench

Multi-cycle FSM that sequences the RV32I datapath around the combinational instruction decoder. It runs the FETCH/DECODE/EXEC/MEM/WB phases and handshakes with the instruction and data memories. It generates the per-phase enables: IR load, PC update, register write and memory request. It sits beside the decoder in the core top level; the decoder supplies datapath selects and this block supplies timing.

---
 rtl/instr_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle control FSM for an RV32I datapath. It walks each instruction
// through FETCH / DECODE / EXEC / MEM / WB and handshakes with the
// instruction and data memories. It produces the per-phase enables: IR load,
// PC update, register write and memory request. The combinational decoder
// beside it supplies the datapath selects; this block supplies only timing.
//
// Handshake semantics: a request output (imem_req / dmem_req) is held high
// for as long as the FSM sits in the phase that owns it. The matching
// *_ready input completes the transfer in the cycle it is seen high. A
// *_ready input is ignored in every other phase.
//
// Optional feature (macro SEQ_PERF_CNT_EN): adds the retired_cnt and
// cycle_cnt performance counter outputs.
//
// Parameters:
//   DATA_WIDTH  instruction word width (default 32)
//   CNT_WIDTH   width of the optional performance counters (default 32)
//
// Ports:
//   clk         core clock
//   rst         synchronous active-high reset
//   run         enable, sampled only at instruction boundaries
//   instr       instruction word from instruction memory
//   imem_ready  instruction memory data valid
//   imem_req    instruction fetch request
//   ir_we       load instruction register
//   dmem_ready  data memory access complete
//   dmem_req    data memory request
//   dmem_we     data memory write (store)
//   reg_we      register file write enable
//   pc_we       PC update, one pulse per retired instruction
//   halt        sticky halt (ecall/ebreak/illegal)
//   illegal     sticky, the halt was caused by an unknown opcode
//   state       current FSM state, for debug
//   retired_cnt (SEQ_PERF_CNT_EN) count of pc_we pulses
//   cycle_cnt   (SEQ_PERF_CNT_EN) count of cycles outside IDLE and HALT
// ---------------------------------------------------------------------------
module instr_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  imem_ready,
   output logic                  imem_req,
   output logic                  ir_we,
   input  logic                  dmem_ready,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic                  reg_we,
   output logic                  pc_we,
   output logic                  halt,
   output logic                  illegal,
   output logic [2:0]            state
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  retired_cnt,
   output logic [CNT_WIDTH-1:0]  cycle_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   state_t     state_q, state_d;
   logic [6:0] op_q, op_d;

   // Only the opcode field is needed here; the rest belongs to the decoder.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr[DATA_WIDTH-1:7];

   logic is_store, is_load, is_known;
   assign is_store = (op_q == OP_STORE);
   assign is_load  = (op_q == OP_LOAD);

   always_comb begin
      is_known = 1'b0;
      case (op_q)
         OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_known = 1'b1;
         default:                           is_known = 1'b0;
      endcase
   end

   // Raw (pre-reset-gating) enables, combinational from state, held op and
   // the ready inputs.
   logic imem_req_raw, ir_we_raw, dmem_req_raw, dmem_we_raw;
   logic reg_we_raw, pc_we_raw, halt_raw, illegal_raw;

   always_comb begin
      imem_req_raw = 1'b0;
      ir_we_raw    = 1'b0;
      dmem_req_raw = 1'b0;
      dmem_we_raw  = 1'b0;
      reg_we_raw   = 1'b0;
      pc_we_raw    = 1'b0;
      halt_raw     = 1'b0;
      illegal_raw  = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req_raw = 1'b1;
            ir_we_raw    = imem_ready;
         end
         S_EXEC: begin
            pc_we_raw = (op_q == OP_BRANCH);
         end
         S_MEM: begin
            dmem_req_raw = 1'b1;
            dmem_we_raw  = is_store;
            pc_we_raw    = is_store & dmem_ready;
         end
         S_WB: begin
            reg_we_raw = 1'b1;
            pc_we_raw  = 1'b1;
         end
         S_HALT: begin
            // HALT is left only through rst, so both flags are sticky.
            halt_raw    = 1'b1;
            illegal_raw = (op_q != OP_SYSTEM);
         end
         default: ;
      endcase
   end

   // rst dominates: nothing is enabled in a reset cycle, even mid-access.
   assign imem_req = imem_req_raw & ~rst;
   assign ir_we    = ir_we_raw    & ~rst;
   assign dmem_req = dmem_req_raw & ~rst;
   assign dmem_we  = dmem_we_raw  & ~rst;
   assign reg_we   = reg_we_raw   & ~rst;
   assign pc_we    = pc_we_raw    & ~rst;
   assign halt     = halt_raw     & ~rst;
   assign illegal  = illegal_raw  & ~rst;
   assign state    = rst ? 3'd0 : state_q;

   // Next state. The pc_we cycle is the instruction boundary, the only
   // point at which run is consulted.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ready) begin
               op_d    = instr[6:0];
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op_q == OP_SYSTEM || !is_known) state_d = S_HALT;
            else                                state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_load || is_store)    state_d = S_MEM;
            else if (op_q == OP_BRANCH) state_d = run ? S_FETCH : S_IDLE;
            else                        state_d = S_WB;
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (is_store) state_d = run ? S_FETCH : S_IDLE;
               else          state_d = S_WB;
            end
         end
         S_WB: begin
            state_d = run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            // Code 7 is unreachable; recover to IDLE if it ever appears.
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= 7'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] retired_q, cycle_q;

   // Both counters wrap naturally past all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= '0;
         cycle_q   <= '0;
      end else begin
         if (pc_we_raw)
            retired_q <= retired_q + 1'b1;
         if (state_q != S_IDLE && state_q != S_HALT)
            cycle_q <= cycle_q + 1'b1;
      end
   end

   assign retired_cnt = retired_q;
   assign cycle_cnt   = cycle_q;
`else
   logic [CNT_WIDTH-1:0] unused_cnt_width;
   assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Each cycle compares
// the debug state and a packed enable vector against hand-computed values.
//
// Enable vector bit order:
//   [7] imem_req [6] ir_we [5] dmem_req [4] dmem_we
//   [3] reg_we   [2] pc_we [1] halt     [0] illegal
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

   localparam int DW = 32;
   localparam int CW = 32;

   localparam logic [7:0] V_NONE  = 8'h00;
   localparam logic [7:0] V_FWAIT = 8'h80;  // fetch, memory not ready
   localparam logic [7:0] V_FRDY  = 8'hC0;  // fetch completes, IR loads
   localparam logic [7:0] V_LDMEM = 8'h20;  // load in MEM
   localparam logic [7:0] V_STMEM = 8'h30;  // store in MEM, waiting
   localparam logic [7:0] V_STRDY = 8'h34;  // store completes, PC updates
   localparam logic [7:0] V_BR    = 8'h04;  // branch in EXEC
   localparam logic [7:0] V_WB    = 8'h0C;
   localparam logic [7:0] V_HALT  = 8'h02;
   localparam logic [7:0] V_ILL   = 8'h03;

   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2,
                          EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_LW    = 32'h0000A103;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_ECALL = 32'h00000073;
   localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;
   localparam logic [31:0] I_JAL   = 32'h008000EF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          run = 1'b0;
   logic [DW-1:0] instr = '0;
   logic          imem_ready = 1'b0;
   logic          dmem_ready = 1'b0;
   logic          imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we;
   logic          halt, illegal;
   logic [2:0]    state;
`ifdef SEQ_PERF_CNT_EN
   logic [CW-1:0] retired_cnt, cycle_cnt;
`endif

   instr_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .instr      (instr),
      .imem_ready (imem_ready),
      .imem_req   (imem_req),
      .ir_we      (ir_we),
      .dmem_ready (dmem_ready),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .reg_we     (reg_we),
      .pc_we      (pc_we),
      .halt       (halt),
      .illegal    (illegal),
      .state      (state)
`ifdef SEQ_PERF_CNT_EN
      ,
      .retired_cnt(retired_cnt),
      .cycle_cnt  (cycle_cnt)
`endif
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Sample this cycle on the falling edge, then move to just after the next
   // rising edge where the caller may change inputs.
   task automatic cyc(input string tag, input logic [2:0] exp_state,
                      input logic [7:0] exp_vec);
      @(negedge clk);
      check({tag, ".state"}, {29'd0, state}, {29'd0, exp_state});
      check({tag, ".en"},
            {24'd0, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we,
             halt, illegal},
            {24'd0, exp_vec});
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      @(posedge clk);
      #1;

      // 1. reset for two cycles, then addi
      rst = 1'b1; run = 1'b1; imem_ready = 1'b1; instr = I_ADDI;
      cyc("rst0", IDLE, V_NONE);
      cyc("rst1", IDLE, V_NONE);
      rst = 1'b0;
      cyc("addi.idle", IDLE,   V_NONE);
      cyc("addi.f",    FETCH,  V_FRDY);
      cyc("addi.d",    DECODE, V_NONE);
      cyc("addi.e",    EXEC,   V_NONE);
      cyc("addi.wb",   WB,     V_WB);

      // 2. lw with two MEM wait cycles
      instr = I_LW; dmem_ready = 1'b0;
      cyc("lw.f",    FETCH,  V_FRDY);
      cyc("lw.d",    DECODE, V_NONE);
      cyc("lw.e",    EXEC,   V_NONE);
      cyc("lw.m0",   MEM,    V_LDMEM);
      cyc("lw.m1",   MEM,    V_LDMEM);
      dmem_ready = 1'b1;
      cyc("lw.m2",   MEM,    V_LDMEM);
      dmem_ready = 1'b0;
      cyc("lw.wb",   WB,     V_WB);

      // 3. sw, with one fetch wait cycle first
      instr = I_SW; imem_ready = 1'b0;
      cyc("sw.fw",   FETCH,  V_FWAIT);
      imem_ready = 1'b1;
      cyc("sw.f",    FETCH,  V_FRDY);
      cyc("sw.d",    DECODE, V_NONE);
      cyc("sw.e",    EXEC,   V_NONE);
      cyc("sw.mw",   MEM,    V_STMEM);
      dmem_ready = 1'b1;
      cyc("sw.m",    MEM,    V_STRDY);
      dmem_ready = 1'b0;

      // 4. beq, run dropped during EXEC -> IDLE after boundary
      instr = I_BEQ;
      cyc("beq.f",   FETCH,  V_FRDY);
      cyc("beq.d",   DECODE, V_NONE);
      run = 1'b0;
      cyc("beq.e",   EXEC,   V_BR);
      cyc("beq.idle0", IDLE, V_NONE);
      cyc("beq.idle1", IDLE, V_NONE);

      // jal takes the WB path
      run = 1'b1; instr = I_JAL;
      cyc("jal.idle", IDLE,  V_NONE);
      cyc("jal.f",   FETCH,  V_FRDY);
      cyc("jal.d",   DECODE, V_NONE);
      cyc("jal.e",   EXEC,   V_NONE);
      run = 1'b0;
      cyc("jal.wb",  WB,     V_WB);
      cyc("jal.idle1", IDLE, V_NONE);

      // 5. ecall -> HALT, sticky even with run low
      run = 1'b1; instr = I_ECALL;
      cyc("ecall.idle", IDLE, V_NONE);
      cyc("ecall.f", FETCH,  V_FRDY);
      cyc("ecall.d", DECODE, V_NONE);
      run = 1'b0;
      for (int i = 0; i < 10; i++) cyc("ecall.halt", HALT, V_HALT);
      rst = 1'b1;
      cyc("ecall.rst", IDLE, V_NONE);
      rst = 1'b0;
      cyc("ecall.post", IDLE, V_NONE);

      // illegal opcode
      run = 1'b1; instr = I_BAD;
      cyc("ill.idle", IDLE,  V_NONE);
      cyc("ill.f",   FETCH,  V_FRDY);
      cyc("ill.d",   DECODE, V_NONE);
      cyc("ill.h0",  HALT,   V_ILL);
      cyc("ill.h1",  HALT,   V_ILL);
      rst = 1'b1;
      cyc("ill.rst", IDLE,   V_NONE);
      rst = 1'b0; run = 1'b0;
      cyc("ill.post", IDLE,  V_NONE);

      // 6. reset while MEM waits on dmem_ready
      run = 1'b1; instr = I_LW; dmem_ready = 1'b0;
      cyc("rmem.idle", IDLE, V_NONE);
      cyc("rmem.f",  FETCH,  V_FRDY);
      cyc("rmem.d",  DECODE, V_NONE);
      cyc("rmem.e",  EXEC,   V_NONE);
      cyc("rmem.m",  MEM,    V_LDMEM);
      rst = 1'b1;
      cyc("rmem.rst", IDLE,  V_NONE);
      rst = 1'b0; run = 1'b0;
      cyc("rmem.post", IDLE, V_NONE);

`ifdef SEQ_PERF_CNT_EN
      // three back-to-back addi: 3 retired, 12 active cycles
      rst = 1'b1;
      cyc("cnt.rst", IDLE, V_NONE);
      check("cnt.ret0", retired_cnt, 32'd0);
      check("cnt.cyc0", cycle_cnt,   32'd0);
      rst = 1'b0; run = 1'b1; instr = I_ADDI;
      cyc("cnt.idle", IDLE, V_NONE);
      for (int k = 0; k < 3; k++) begin
         cyc("cnt.f", FETCH,  V_FRDY);
         cyc("cnt.d", DECODE, V_NONE);
         cyc("cnt.e", EXEC,   V_NONE);
         if (k == 2) run = 1'b0;
         cyc("cnt.wb", WB,    V_WB);
      end
      cyc("cnt.idle1", IDLE, V_NONE);
      check("cnt.retired", retired_cnt, 32'd3);
      check("cnt.cycles",  cycle_cnt,   32'd12);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
